load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  MEM-stage load/store unit of the RV32I pipeline; sits directly upstream of data_mem_top.
//  Turns a decoded load/store (funct3, byte address, rs2 data) into a data-memory request:
//  word address, byte mask, lane-replicated store data.
//  Loads: waits out the 1-cycle synchronous memory read, stalls the pipeline meanwhile,
//  then byte/half-selects and sign/zero-extends the returned word for writeback.
//  Rejects misaligned or illegal accesses before they reach memory.
// PARAMETERS
//  ADDR_W  8  width of memory word address; address = ls_addr[ADDR_W+1:2]
// PORTS
//  clk         in   1       pipeline clock
//  rst         in   1       asynchronous, active-high reset
//  ls_valid    in   1       MEM-stage instruction is a valid memory op this cycle
//  ls_load     in   1       op is a load (LB/LH/LW/LBU/LHU)
//  ls_store    in   1       op is a store (SB/SH/SW)
//  ls_funct3   in   3       RV32I funct3 of the op
//  ls_addr     in   32      effective byte address (rs1+imm)
//  ls_wdata    in   32      rs2 store data
//  mem_rdata   in   32      data_out from data memory, valid 1 cycle after read request
//  request     out  1       memory access strobe (to data_mem_top.request)
//  we_re       out  1       1 = write, 0 = read
//  load        out  1       high with a read request
//  mask        out  4       byte-lane enables, bit i = byte lane i
//  address     out  ADDR_W  word address
//  data_in     out  32      lane-replicated store data
//  rd_data     out  32      extended load result
//  rd_valid    out  1       1-cycle pulse: rd_data holds a new load result
//  stall       out  1       hold IF..MEM stages this cycle
//  fault       out  1       misaligned or illegal funct3; access suppressed
// BEHAVIOUR
//  Reset (async): state=IDLE; rd_data=0, rd_valid=0, stall=0, fault=0; request/we_re/load=0.
//  Reset mid-LOAD_WAIT: load dropped, no rd_valid, back to IDLE.
//  FSM: IDLE, LOAD_WAIT. Memory-side outputs are combinational in IDLE, zero in LOAD_WAIT.
//  Op legal iff funct3 in {000,001,010} (store) / {000,001,010,100,101} (load).
//  Aligned iff H: ls_addr[0]=0; W: ls_addr[1:0]=0.
//  ls_load takes priority when ls_load and ls_store are both 1.
//  IDLE, ls_valid & ~legal|~aligned: fault=1 same cycle; request=0; no stall; stay IDLE.
//  IDLE, legal aligned store: request=1, we_re=1, load=0; 1-cycle op, stall=0.
//   SB: mask=4'b0001<<addr[1:0], data_in={4{wdata[7:0]}}
//   SH: mask=addr[1]?1100:0011, data_in={2{wdata[15:0]}}
//   SW: mask=1111, data_in=wdata
//  IDLE, legal aligned load: request=1, we_re=0, load=1, mask=1111, stall=1.
//   Latch funct3 and addr[1:0]; go LOAD_WAIT.
//  LOAD_WAIT (exactly 1 cycle): stall=0, request=0, ls_* ignored. Capture
//   extend(select(mem_rdata)) into rd_data, pulse rd_valid; result visible the cycle after
//   LOAD_WAIT. Return to IDLE. Total load latency: 2 cycles from issue to rd_valid.
//   LB/LBU: byte at offset*8, sign/zero-extend; LH/LHU: half at addr[1]*16; LW: whole word.
//  rd_data holds its last value until the next load completes; stores never change it.
//  Back-to-back: a new op may issue in the IDLE cycle right after LOAD_WAIT.
//  fault is combinational, never registered; it never touches the FSM.
// TESTING
//  SW addr 0x10, wdata 0xDEADBEEF -> request=1, we_re=1, mask=1111, address=0x04,
//   data_in=0xDEADBEEF, stall=0
//  SB addr 0x13, wdata 0x000000A5 -> mask=1000, data_in=0xA5A5A5A5, address=0x04
//  LB addr 0x13, mem word 0x80FF1234 -> stall=1 for 1 cycle, then rd_valid=1,
//   rd_data=0xFFFFFF80; LBU same -> 0x00000080
//  LH addr 0x12, same word -> rd_data=0xFFFF80FF; LHU -> 0x000080FF; LW addr 0x10 -> 0x80FF1234
//  LW addr 0x06 / SH addr 0x03 / load funct3=011 -> fault=1, request=0, stall=0, no rd_valid
//  rst high during LOAD_WAIT -> immediately stall=0, rd_valid=0, rd_data=0, state IDLE

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit for the MEM stage of the RV32I pipeline.
// Decodes a load or store into a data-memory request (word address, byte mask,
// lane-replicated store data), stalls for one cycle while the synchronous memory
// read completes, then lane-selects and extends the returned word for writeback.
// Misaligned or illegal accesses raise fault and never reach memory.
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ls_valid,
  input  logic              ls_load,
  input  logic              ls_store,
  input  logic [2:0]        ls_funct3,
  input  logic [31:0]       ls_addr,
  input  logic [31:0]       ls_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              request,
  output logic              we_re,
  output logic              load,
  output logic [3:0]        mask,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       data_in,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              stall,
  output logic              fault
);

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  offset_q, offset_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;

  logic        op_valid;
  logic        op_is_load;
  logic        op_legal;
  logic        op_aligned;
  logic        op_bad;
  logic        op_go;

  // Upper byte-address bits fall outside the data memory and are dropped.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^ls_addr[31:ADDR_W+2];

  // Selects the addressed byte/half of the returned word and extends it to 32 bits.
  function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                              input logic [1:0]  offset,
                                              input logic [31:0] word);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic [31:0]        result;
    byte_s = $signed(word[{offset, 3'b000} +: 8]);
    half_s = $signed(word[{offset[1], 4'b0000} +: 16]);
    case (f3)
      3'b000:  result = 32'(byte_s);
      3'b001:  result = 32'(half_s);
      3'b100:  result = {24'd0, byte_s};
      3'b101:  result = {16'd0, half_s};
      default: result = word;
    endcase
    return result;
  endfunction

  // Builds {mask, data_in} for a store: lanes enabled at the access position,
  // store data replicated across all lanes so memory picks the enabled ones.
  function automatic logic [35:0] store_lanes(input logic [1:0]  size,
                                              input logic [1:0]  offset,
                                              input logic [31:0] wdata);
    logic [3:0]  lane_mask;
    logic [31:0] lane_data;
    case (size)
      2'b00: begin
        lane_mask = 4'b0001 << offset;
        lane_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        lane_mask = offset[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata[15:0]}};
      end
      default: begin
        lane_mask = 4'b1111;
        lane_data = wdata;
      end
    endcase
    return {lane_mask, lane_data};
  endfunction

  // Classify the incoming op: legality by funct3, alignment by access size.
  always_comb begin
    op_valid   = ls_valid & (ls_load | ls_store);
    op_is_load = ls_load;
    if (ls_load) begin
      op_legal = (ls_funct3 == 3'b000) || (ls_funct3 == 3'b001) ||
                 (ls_funct3 == 3'b010) || (ls_funct3 == 3'b100) ||
                 (ls_funct3 == 3'b101);
    end else begin
      op_legal = (ls_funct3 == 3'b000) || (ls_funct3 == 3'b001) ||
                 (ls_funct3 == 3'b010);
    end
    case (ls_funct3[1:0])
      2'b01:   op_aligned = ~ls_addr[0];
      2'b10:   op_aligned = (ls_addr[1:0] == 2'b00);
      default: op_aligned = 1'b1;
    endcase
    op_bad = op_valid & ~(op_legal & op_aligned);
    op_go  = op_valid & op_legal & op_aligned;
  end

  // Next-state and memory-side outputs; outputs are live only in IDLE outside reset.
  always_comb begin
    state_d    = state_q;
    funct3_d   = funct3_q;
    offset_d   = offset_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    request    = 1'b0;
    we_re      = 1'b0;
    load       = 1'b0;
    mask       = 4'b0000;
    address    = '0;
    data_in    = 32'd0;
    stall      = 1'b0;
    fault      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst) begin
          fault = op_bad;
          if (op_go) begin
            request = 1'b1;
            address = ls_addr[ADDR_W+1:2];
            if (op_is_load) begin
              load     = 1'b1;
              mask     = 4'b1111;
              stall    = 1'b1;
              funct3_d = ls_funct3;
              offset_d = ls_addr[1:0];
              state_d  = LOAD_WAIT;
            end else begin
              we_re           = 1'b1;
              {mask, data_in} = store_lanes(ls_funct3[1:0], ls_addr[1:0], ls_wdata);
            end
          end
        end
      end
      LOAD_WAIT: begin
        rd_data_d  = extend_load(funct3_q, offset_q, mem_rdata);
        rd_valid_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched load attributes and writeback result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      funct3_q   <= 3'b000;
      offset_q   <= 2'b00;
      rd_data_q  <= 32'd0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      funct3_q   <= funct3_d;
      offset_q   <= offset_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed cases plus a randomized stream checked
// against a byte-addressed reference memory model; a word-wide memory stub with a
// one-cycle registered read stands in for data_mem_top.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ls_valid = 1'b0;
  logic        ls_load = 1'b0;
  logic        ls_store = 1'b0;
  logic [2:0]  ls_funct3 = 3'b000;
  logic [31:0] ls_addr = 32'd0;
  logic [31:0] ls_wdata = 32'd0;
  logic [31:0] mem_rdata = 32'd0;
  logic        request, we_re, load, rd_valid, stall, fault;
  logic [3:0]  mask;
  logic [7:0]  address;
  logic [31:0] data_in, rd_data;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [31:0] exp_rd = 32'd0;
  logic        exp_rdv = 1'b0;

  logic [7:0]  refmem [0:1023];
  logic [31:0] stub [0:255];

  logic [48:0] obs_all;
  assign obs_all = {request, we_re, load, mask, address, data_in, stall, fault};

  load_store_unit #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .ls_valid(ls_valid), .ls_load(ls_load), .ls_store(ls_store),
    .ls_funct3(ls_funct3), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .mem_rdata(mem_rdata),
    .request(request), .we_re(we_re), .load(load), .mask(mask), .address(address),
    .data_in(data_in), .rd_data(rd_data), .rd_valid(rd_valid), .stall(stall), .fault(fault)
  );

  always #5 clk = ~clk;

  // Memory stub: masked writes, registered read data one cycle after the request.
  always @(posedge clk) begin
    if (request && we_re) begin
      for (int i = 0; i < 4; i++)
        if (mask[i]) stub[address][8*i +: 8] <= data_in[8*i +: 8];
    end
    if (request && !we_re) mem_rdata <= stub[address];
  end

  function automatic int op_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit op_legal(input bit ld, input logic [2:0] f3);
    if (ld) return (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    return f3 <= 2;
  endfunction

  // Reference load value straight from the byte array, little-endian, with extension.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    longint v = 0;
    int n = op_size(f3);
    int base = int'(a[9:0]);
    for (int i = 0; i < n; i++) v = v | (longint'(refmem[base + i]) << (8 * i));
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n = op_size(f3);
    int base = int'(a[9:0]);
    for (int i = 0; i < n; i++) refmem[base + i] = 8'((wd >> (8 * i)) & 32'hFF);
  endtask

  task automatic drive(input bit v, input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    ls_valid = v; ls_load = ld; ls_store = st; ls_funct3 = f3; ls_addr = a; ls_wdata = wd;
    #1;
  endtask

  task automatic test_reset;
    drive(1, 0, 1, 3'b010, 32'h10, 32'h12345678);
    cmp_cnt++;
    if (obs_all !== 49'd0) begin
      err_cnt++; $display("FAIL reset_outputs: got %h want 0", obs_all);
    end
    cmp_cnt++;
    if ({rd_valid, rd_data} !== 33'd0) begin
      err_cnt++; $display("FAIL reset_rd: got %b/%h want 0/0", rd_valid, rd_data);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_store_directed;
    drive(1, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
    ref_store(3'b010, 32'h10, 32'hDEADBEEF);
    cmp_cnt++;
    if (obs_all !== {1'b1, 1'b1, 1'b0, 4'hF, 8'h04, 32'hDEADBEEF, 1'b0, 1'b0}) begin
      err_cnt++; $display("FAIL sw_0x10: got %h want req/we/F/04/DEADBEEF", obs_all);
    end
    drive(1, 0, 1, 3'b000, 32'h13, 32'h000000A5);
    ref_store(3'b000, 32'h13, 32'h000000A5);
    cmp_cnt++;
    if (obs_all !== {1'b1, 1'b1, 1'b0, 4'b1000, 8'h04, 32'hA5A5A5A5, 1'b0, 1'b0}) begin
      err_cnt++; $display("FAIL sb_0x13: got %h want mask 1000 data A5A5A5A5", obs_all);
    end
    drive(1, 0, 1, 3'b001, 32'h16, 32'h0000C3D2);
    ref_store(3'b001, 32'h16, 32'h0000C3D2);
    cmp_cnt++;
    if ({request, we_re, mask, address, data_in} !== {1'b1, 1'b1, 4'b1100, 8'h05, 32'hC3D2C3D2}) begin
      err_cnt++; $display("FAIL sh_0x16: got %h want mask 1100 data C3D2C3D2", obs_all);
    end
  endtask

  task automatic test_load_directed;
    logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] adrs [5] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
    logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h80FF1234};
    drive(1, 0, 1, 3'b010, 32'h10, 32'h80FF1234);
    ref_store(3'b010, 32'h10, 32'h80FF1234);
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 0, f3s[k], adrs[k], 32'hFFFFFFFF);
      cmp_cnt++;
      if ({request, we_re, load, mask, address, stall, fault} !==
          {1'b1, 1'b0, 1'b1, 4'hF, 8'h04, 1'b1, 1'b0}) begin
        err_cnt++; $display("FAIL load_issue_%0d: got %h want read req F/04 stall", k, obs_all);
      end
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
      cmp_cnt++;
      if ({request, stall, rd_valid} !== 3'b000) begin
        err_cnt++; $display("FAIL load_wait_%0d: req/stall/rdv got %b%b%b want 000", k, request, stall, rd_valid);
      end
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
      cmp_cnt++;
      if ({rd_valid, rd_data} !== {1'b1, exps[k]}) begin
        err_cnt++; $display("FAIL load_result_%0d: got %b/%h want 1/%h", k, rd_valid, rd_data, exps[k]);
      end
    end
    exp_rd = 32'h80FF1234;
    drive(1, 0, 1, 3'b010, 32'h20, 32'h01020304);
    ref_store(3'b010, 32'h20, 32'h01020304);
    drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
    cmp_cnt++;
    if ({rd_valid, rd_data} !== {1'b0, exp_rd}) begin
      err_cnt++; $display("FAIL store_keeps_rd: got %b/%h want 0/%h", rd_valid, rd_data, exp_rd);
    end
  endtask

  task automatic test_priority;
    drive(1, 1, 1, 3'b010, 32'h10, 32'h0);
    cmp_cnt++;
    if ({request, we_re, load, stall} !== 4'b1011) begin
      err_cnt++; $display("FAIL both_set_load_wins: got %b%b%b%b want 1011", request, we_re, load, stall);
    end
    drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
    drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
    cmp_cnt++;
    if ({rd_valid, rd_data} !== {1'b1, model_load(3'b010, 32'h10)}) begin
      err_cnt++; $display("FAIL both_set_result: got %b/%h want 1/%h", rd_valid, rd_data, model_load(3'b010, 32'h10));
    end
    exp_rd = model_load(3'b010, 32'h10);
  endtask

  task automatic test_faults;
    bit          lds [5] = '{1, 0, 1, 0, 1};
    logic [2:0]  f3s [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b101};
    logic [31:0] ads [5] = '{32'h06, 32'h03, 32'h10, 32'h10, 32'h11};
    for (int k = 0; k < 5; k++) begin
      drive(1, lds[k], !lds[k], f3s[k], ads[k], 32'hFFFFFFFF);
      cmp_cnt++;
      if ({request, stall, fault} !== 3'b001) begin
        err_cnt++; $display("FAIL fault_%0d: req/stall/fault got %b%b%b want 001", k, request, stall, fault);
      end
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
      cmp_cnt++;
      if ({rd_valid, rd_data} !== {1'b0, exp_rd}) begin
        err_cnt++; $display("FAIL fault_no_rdv_%0d: got %b/%h want 0/%h", k, rd_valid, rd_data, exp_rd);
      end
    end
  endtask

  task automatic test_reset_mid_load;
    drive(1, 1, 0, 3'b010, 32'h10, 32'h0);
    @(negedge clk);
    ls_valid = 1'b0;
    rst = 1'b1;
    #1;
    cmp_cnt++;
    if ({stall, request, load, rd_valid, rd_data} !== 36'd0) begin
      err_cnt++; $display("FAIL reset_in_wait: stall/req/load/rdv %b%b%b%b rd %h want 0", stall, request, load, rd_valid, rd_data);
    end
    @(negedge clk); rst = 1'b0;
    drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
    cmp_cnt++;
    if ({rd_valid, rd_data} !== 33'd0) begin
      err_cnt++; $display("FAIL reset_wait_no_rdv: got %b/%h want 0/0", rd_valid, rd_data);
    end
    exp_rd = 32'd0;
    exp_rdv = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [2:0]  legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    // Define every memory word through the DUT so stub and model agree.
    for (int w = 0; w < 256; w++) begin
      logic [31:0] wd;
      wd = $urandom;
      drive(1, 0, 1, 3'b010, {22'($urandom), 8'(w), 2'b00}, wd);
      ref_store(3'b010, {22'd0, 8'(w), 2'b00}, wd);
      cmp_cnt++;
      if ({request, we_re, mask, address, data_in} !== {1'b1, 1'b1, 4'hF, 8'(w), wd}) begin
        err_cnt++; $display("FAIL fill_%0d: got %h want word write %h", w, obs_all, wd);
      end
    end
    for (int it = 0; it < 400; it++) begin
      bit v, ld, st, op, legal, aligned, bad, go;
      logic [2:0]  f3;
      logic [31:0] a, wd, edata;
      logic [3:0]  emask;
      int n, off, r;
      r  = $urandom_range(0, 9);
      v  = (r != 0);
      ld = $urandom_range(0, 1) == 1;
      st = ld ? ($urandom_range(0, 1) == 1) : (r != 1);
      f3 = ($urandom_range(0, 6) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, ld ? 4 : 2)];
      n  = op_size(f3);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(n) - 32'd1);
      wd = $urandom;
      drive(v, ld, st, f3, a, wd);
      cmp_cnt++;
      if ({rd_valid, rd_data} !== {exp_rdv, exp_rd}) begin
        err_cnt++; $display("FAIL rnd_rd_%0d: got %b/%h want %b/%h", it, rd_valid, rd_data, exp_rdv, exp_rd);
      end
      exp_rdv = 1'b0;
      op      = v && (ld || st);
      legal   = op_legal(ld, f3);
      aligned = (int'(a[9:0]) % n) == 0;
      bad     = op && !(legal && aligned);
      go      = op && legal && aligned;
      cmp_cnt++;
      if ({request, we_re, load, stall, fault} !== {go, go && !ld, go && ld, go && ld, bad}) begin
        err_cnt++; $display("FAIL rnd_ctl_%0d: req/we/ld/stall/fault got %b%b%b%b%b want %b%b%b%b%b", it,
                            request, we_re, load, stall, fault, go, go && !ld, go && ld, go && ld, bad);
      end
      if (go) begin
        off = int'(a[1:0]);
        emask = 4'hF;
        edata = wd;
        if (!ld) begin
          for (int i = 0; i < 4; i++) begin
            emask[i] = (i >= off) && (i < off + n);
            edata[8*i +: 8] = wd[8*(i % n) +: 8];
          end
        end
        cmp_cnt++;
        if ({mask, address} !== {emask, a[9:2]}) begin
          err_cnt++; $display("FAIL rnd_mask_addr_%0d: got %b/%h want %b/%h", it, mask, address, emask, a[9:2]);
        end
        if (!ld) begin
          cmp_cnt++;
          if (data_in !== edata) begin
            err_cnt++; $display("FAIL rnd_wdata_%0d: got %h want %h", it, data_in, edata);
          end
          ref_store(f3, a, wd);
        end else begin
          logic [31:0] nv;
          nv = model_load(f3, a);
          drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1, 3'($urandom), $urandom, $urandom);
          cmp_cnt++;
          if ({request, stall, fault, rd_valid} !== 4'b0000) begin
            err_cnt++; $display("FAIL rnd_wait_%0d: req/stall/fault/rdv got %b%b%b%b want 0000", it, request, stall, fault, rd_valid);
          end
          exp_rd  = nv;
          exp_rdv = 1'b1;
        end
      end
    end
    drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
    cmp_cnt++;
    if ({rd_valid, rd_data} !== {exp_rdv, exp_rd}) begin
      err_cnt++; $display("FAIL rnd_rd_last: got %b/%h want %b/%h", rd_valid, rd_data, exp_rdv, exp_rd);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) refmem[i] = 8'd0;
    test_reset;
    test_store_directed;
    test_load_directed;
    test_priority;
    test_faults;
    test_reset_mid_load;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
